fsm_seq_gen: RTL and testbench

// - Autonomous 4-state Moore sequencer; no data inputs, advances on its own after reset release.
// - Cycles S0->S1->S2->S3->S0, dwelling a programmable number of clocks in each state.
// - Exposes current state code and a Moore flag y; used as a timing/pattern source and lab FSM demo.

---
 rtl/fsm_seq_gen.sv | 87 ++++++++
 tb/tb_fsm_seq_gen.sv | 131 +++++++++++++
 2 files changed

// File: rtl/fsm_seq_gen.sv
// rtl/fsm_seq_gen.sv - autonomous four-state Moore sequencer with per-state dwell counts
module fsm_seq_gen #(
  parameter int DWELL0 = 1,
  parameter int DWELL1 = 2,
  parameter int DWELL2 = 3,
  parameter int DWELL3 = 4,
  parameter int CNT_W  = 8
) (
  input  logic       clk,
  input  logic       rst,
  output logic       y,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  // A dwell of 0 is clamped to 1 so every state lasts at least one clock.
  localparam int EFF0 = (DWELL0 < 1) ? 1 : DWELL0;
  localparam int EFF1 = (DWELL1 < 1) ? 1 : DWELL1;
  localparam int EFF2 = (DWELL2 < 1) ? 1 : DWELL2;
  localparam int EFF3 = (DWELL3 < 1) ? 1 : DWELL3;

  // Terminal counter value for each state (D-1); fits because D <= 2**CNT_W.
  localparam logic [CNT_W-1:0] LAST0 = CNT_W'(EFF0 - 1);
  localparam logic [CNT_W-1:0] LAST1 = CNT_W'(EFF1 - 1);
  localparam logic [CNT_W-1:0] LAST2 = CNT_W'(EFF2 - 1);
  localparam logic [CNT_W-1:0] LAST3 = CNT_W'(EFF3 - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             y_q, y_d;
  logic [CNT_W-1:0] last;

  // Select the terminal count belonging to the current state.
  always_comb begin
    last = LAST0;
    case (state_q)
      S0: last = LAST0;
      S1: last = LAST1;
      S2: last = LAST2;
      S3: last = LAST3;
      default: last = LAST0;
    endcase
  end

  // Next-state logic: count up, or advance and clear at (or beyond) the terminal count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    if (cnt_q >= last) begin
      // Counts above the terminal value are treated as terminal so the
      // sequencer always recovers on the next edge.
      cnt_d = '0;
      case (state_q)
        S0: state_d = S1;
        S1: state_d = S2;
        S2: state_d = S3;
        S3: state_d = S0;
        default: state_d = S0;
      endcase
    end
    // y is computed from the next state so it is registered alongside it.
    y_d = (state_d == S3);
  end

  // State, counter and flag registers; reset wins over advancing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S0;
      cnt_q   <= '0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

  assign state = state_q;
  assign y     = y_q;

endmodule

// File: tb/tb_fsm_seq_gen.sv
// tb/tb_fsm_seq_gen.sv - directed self-checking bench for fsm_seq_gen
module tb_fsm_seq_gen;

  logic       clk;
  logic       rst_a, rst_b;
  logic       y_a, y_b;
  logic [1:0] state_a, state_b;

  int checks;
  int errors;

  // Hand-computed per-edge state codes after reset release (index 0 = reset edge).
  int seq_a [10] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};
  int seq_b [8]  = '{0, 1, 2, 3, 3, 3, 3, 3};

  fsm_seq_gen dut_a (
    .clk   (clk),
    .rst   (rst_a),
    .y     (y_a),
    .state (state_a)
  );

  fsm_seq_gen #(
    .DWELL0 (0),
    .DWELL1 (1),
    .DWELL2 (1),
    .DWELL3 (5),
    .CNT_W  (8)
  ) dut_b (
    .clk   (clk),
    .rst   (rst_b),
    .y     (y_b),
    .state (state_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle past it before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ya_high, yb_high, ya_rise, yb_rise;
    logic ya_prev, yb_prev;
    checks  = 0;
    errors  = 0;
    rst_a   = 1'b1;
    rst_b   = 1'b1;
    ya_high = 0;
    yb_high = 0;
    ya_rise = 0;
    yb_rise = 0;

    // Reset held for five edges.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_state_a", int'(state_a), 0);
      check("rst_y_a", int'(y_a), 0);
      check("rst_state_b", int'(state_b), 0);
      check("rst_y_b", int'(y_b), 0);
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    ya_prev = y_a;
    yb_prev = y_b;

    // Free run / long run: 600 edges, 60 default periods and 75 override periods.
    for (int i = 1; i <= 600; i++) begin
      tick();
      check("run_state_a", int'(state_a), seq_a[i % 10]);
      check("run_y_a", int'(y_a), (seq_a[i % 10] == 3) ? 1 : 0);
      check("run_state_b", int'(state_b), seq_b[i % 8]);
      check("run_y_b", int'(y_b), (seq_b[i % 8] == 3) ? 1 : 0);
      if (y_a) ya_high++;
      if (y_b) yb_high++;
      if (y_a && !ya_prev) ya_rise++;
      if (y_b && !yb_prev) yb_rise++;
      ya_prev = y_a;
      yb_prev = y_b;
    end
    check("long_y_high_a", ya_high, 240);
    check("long_y_pulses_a", ya_rise, 60);
    check("long_y_high_b", yb_high, 375);
    check("long_y_pulses_b", yb_rise, 75);

    // Mid-run reset while in S2 with cnt=1.
    for (int i = 1; i <= 4; i++) tick();
    check("pre_mid_state", int'(state_a), 2);
    rst_a = 1'b1;
    tick();
    check("mid_rst_state", int'(state_a), 0);
    check("mid_rst_y", int'(y_a), 0);
    rst_a = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("restart_state", int'(state_a), seq_a[i % 10]);
      check("restart_y", int'(y_a), (seq_a[i % 10] == 3) ? 1 : 0);
    end

    // Reset held across the S3->S0 boundary.
    for (int i = 1; i <= 8; i++) tick();
    check("pre_hold_state", int'(state_a), 3);
    rst_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_state", int'(state_a), 0);
      check("hold_y", int'(y_a), 0);
    end
    rst_a = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("post_hold_state", int'(state_a), seq_a[i % 10]);
      check("post_hold_y", int'(y_a), (seq_a[i % 10] == 3) ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
